frame_snapshot_mux: RTL and testbench

//  Parametrised successor to the single-frame address mux. Buffers up to DEPTH decoded

---
 rtl/frame_snapshot_mux_if.sv | 25 ++
 rtl/frame_snapshot_mux.sv | 153 +++++++++++++++
 tb/tb_frame_snapshot_mux.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/frame_snapshot_mux_if.sv
// Bus between the frame FIFO and its two neighbours: decoded frames come in,
// MCU address/pop/clear go in, registered read data and flags come out.
interface frame_snapshot_mux_if #(
  parameter int FRAME_BYTES = 12,
  parameter int ADDR_W      = 4
);
  logic [FRAME_BYTES*8-1:0] frame_data;
  logic                     frame_valid;
  logic [ADDR_W-1:0]        address;
  logic                     pop;
  logic                     clear_ovf;
  logic [7:0]               parallel_out;
  logic                     valid;
  logic                     overflow;

  modport master (
    output frame_data, frame_valid, address, pop, clear_ovf,
    input  parallel_out, valid, overflow
  );

  modport slave (
    input  frame_data, frame_valid, address, pop, clear_ovf,
    output parallel_out, valid, overflow
  );
endinterface

// File: rtl/frame_snapshot_mux.sv
// Frame FIFO between serial_decode and the MCU bus: DEPTH frame slots, byte reads of the head frame.
// Optional per-frame capture timestamp is enabled with `define SNAPSHOT_TIMESTAMP_EN.
module frame_snapshot_mux #(
  parameter int FRAME_BYTES = 12,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 4,
  parameter int DROP_OLDEST = 0,
  parameter int TS_BYTES    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  frame_snapshot_mux_if.slave  bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int FRAME_W = FRAME_BYTES * 8;
  localparam int TS_W    = TS_BYTES * 8;
  localparam bit DROP    = (DROP_OLDEST != 0);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = '1;

  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] f, input logic [31:0] idx);
    logic [FRAME_W-1:0] s;
    s = f >> {idx[28:0], 3'b000};
    return s[7:0];
  endfunction

  function automatic logic [7:0] ts_byte(input logic [TS_W-1:0] t, input logic [31:0] idx);
    logic [TS_W-1:0] s;
    s = t >> {idx[28:0], 3'b000};
    return s[7:0];
  endfunction

  function automatic logic [7:0] status_byte(input logic ovf, input logic [CNT_W-1:0] cnt);
    logic full_f;
    logic empty_f;
    full_f  = (cnt == CNT_W'(DEPTH));
    empty_f = (cnt == '0);
    return {ovf, full_f, empty_f, 5'(cnt)};
  endfunction

  logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               ovf_q, ovf_nxt;
  logic               full, empty, empty_nxt;
  logic               pop_ok, overwrite, push, adv_rd, ovf_evt;
  logic [FRAME_W-1:0] mem [DEPTH];
  logic [FRAME_W-1:0] head_frame;
  logic [TS_W-1:0]    head_ts;
  logic               head_bypass;
  logic [31:0]        addr_i;
  logic [7:0]         rd_byte_p0;
  logic [7:0]         rd_byte_p1;
  logic               vld_p1;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = bus.pop && !empty;
  // A full FIFO is never empty, so a pop there always succeeds and frees the slot.
  assign overwrite = bus.frame_valid && full && !bus.pop && DROP;
  assign push      = bus.frame_valid && (!full || pop_ok || DROP);
  assign adv_rd    = pop_ok || overwrite;
  assign ovf_evt   = bus.frame_valid && full && !pop_ok;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    ovf_nxt    = ovf_q;
    if (push)
      wr_ptr_nxt = wr_ptr + PTR_W'(1);
    if (adv_rd)
      rd_ptr_nxt = rd_ptr + PTR_W'(1);
    if (push && !adv_rd)
      count_nxt = count + CNT_W'(1);
    else if (!push && adv_rd)
      count_nxt = count - CNT_W'(1);
    if (ovf_evt)
      ovf_nxt = 1'b1;
    else if (bus.clear_ovf)
      ovf_nxt = 1'b0;
  end

  assign empty_nxt = (count_nxt == '0);

  // Reads show the state after this edge, so a frame landing in the new head slot is forwarded.
  assign head_bypass = push && (wr_ptr == rd_ptr_nxt);
  assign head_frame  = head_bypass ? bus.frame_data : mem[rd_ptr_nxt];

`ifdef SNAPSHOT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_mem [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ts_cnt <= '0;
    else
      ts_cnt <= ts_cnt + TS_W'(1);
  end

  always_ff @(posedge clock) begin
    if (push)
      ts_mem[wr_ptr] <= ts_cnt;
  end

  assign head_ts = head_bypass ? ts_cnt : ts_mem[rd_ptr_nxt];
`else
  assign head_ts = '0;
`endif

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= bus.frame_data;
  end

  always_comb begin
    rd_byte_p0 = 8'h00;
    addr_i     = 32'(bus.address);
    if (bus.address == STATUS_ADDR)
      rd_byte_p0 = status_byte(ovf_nxt, count_nxt);
    else if (addr_i < FRAME_BYTES) begin
      if (!empty_nxt)
        rd_byte_p0 = frame_byte(head_frame, addr_i);
    end else if (addr_i < FRAME_BYTES + TS_BYTES) begin
      if (!empty_nxt)
        rd_byte_p0 = ts_byte(head_ts, addr_i - FRAME_BYTES);
    end
  end

  // Stage p0 -> p1: FIFO state and registered read port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf_q      <= 1'b0;
      vld_p1     <= 1'b0;
      rd_byte_p1 <= 8'h00;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      ovf_q      <= ovf_nxt;
      vld_p1     <= !empty_nxt;
      rd_byte_p1 <= rd_byte_p0;
    end
  end

  assign bus.parallel_out = rd_byte_p1;
  assign bus.valid        = vld_p1;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_frame_snapshot_mux.sv
// Random and directed stimulus for frame_snapshot_mux, drop-new and drop-oldest builds side by side,
// checked against a queue-based model of the frame FIFO.
module tb_frame_snapshot_mux;
  localparam int FB       = 12;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 4;
  localparam int TS_BYTES = 2;

  typedef logic [FB*8-1:0] frame_t;
  typedef frame_t fq_t[$];
  typedef logic [15:0] ts_t;
  typedef ts_t tq_t[$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  frame_snapshot_mux_if #(.FRAME_BYTES(FB), .ADDR_W(ADDR_W)) bus0 ();
  frame_snapshot_mux_if #(.FRAME_BYTES(FB), .ADDR_W(ADDR_W)) bus1 ();

  assign bus1.frame_data  = bus0.frame_data;
  assign bus1.frame_valid = bus0.frame_valid;
  assign bus1.address     = bus0.address;
  assign bus1.pop         = bus0.pop;
  assign bus1.clear_ovf   = bus0.clear_ovf;

  frame_snapshot_mux #(.FRAME_BYTES(FB), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                       .DROP_OLDEST(0), .TS_BYTES(TS_BYTES)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0));

  frame_snapshot_mux #(.FRAME_BYTES(FB), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
                       .DROP_OLDEST(1), .TS_BYTES(TS_BYTES)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  fq_t q0, q1;
  tq_t t0, t1;
  bit  ovf0, ovf1;
  ts_t tb_ts;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic frame_t mk(input logic [7:0] base);
    frame_t f;
    for (int i = 0; i < FB; i++) f[i*8 +: 8] = base + 8'(i);
    return f;
  endfunction

  // Expected byte at an address, given the FIFO contents after the edge.
  function automatic logic [7:0] exp_map(input int a, input fq_t q, input tq_t tq, input bit ovf);
    int n;
    n = q.size();
    if (a == 2**ADDR_W - 1)
      return {ovf, n == DEPTH, n == 0, 5'(n)};
    if (a < FB)
      return (n > 0) ? q[0][a*8 +: 8] : 8'h00;
    if (a < FB + TS_BYTES) begin
`ifdef SNAPSHOT_TIMESTAMP_EN
      return (n > 0) ? tq[0][(a-FB)*8 +: 8] : 8'h00;
`else
      return 8'h00;
`endif
    end
    return 8'h00;
  endfunction

  task automatic model_step(ref fq_t q, ref tq_t tq, ref bit ovf, input bit drop, input ts_t cap);
    bit pop_ok;
    bit evt;
    pop_ok = bus0.pop && (q.size() > 0);
    evt    = 1'b0;
    if (bus0.frame_valid) begin
      if (q.size() < DEPTH || pop_ok) begin
        if (pop_ok) begin
          void'(q.pop_front());
          void'(tq.pop_front());
        end
        q.push_back(bus0.frame_data);
        tq.push_back(cap);
      end else begin
        evt = 1'b1;
        if (drop) begin
          void'(q.pop_front());
          void'(tq.pop_front());
          q.push_back(bus0.frame_data);
          tq.push_back(cap);
        end
      end
    end else if (pop_ok) begin
      void'(q.pop_front());
      void'(tq.pop_front());
    end
    if (evt)
      ovf = 1'b1;
    else if (bus0.clear_ovf)
      ovf = 1'b0;
  endtask

  task automatic step(input frame_t fd, input bit fv, input logic [3:0] a, input bit p, input bit c);
    bus0.frame_data  = fd;
    bus0.frame_valid = fv;
    bus0.address     = a;
    bus0.pop         = p;
    bus0.clear_ovf   = c;
    @(posedge clock);
    model_step(q0, t0, ovf0, 1'b0, tb_ts);
    model_step(q1, t1, ovf1, 1'b1, tb_ts);
    tb_ts = tb_ts + 16'd1;
    @(negedge clock);
    check("d0_out", 32'(bus0.parallel_out), 32'(exp_map(int'(a), q0, t0, ovf0)));
    check("d0_valid", 32'(bus0.valid), 32'(q0.size() > 0));
    check("d0_ovf", 32'(bus0.overflow), 32'(ovf0));
    check("d1_out", 32'(bus1.parallel_out), 32'(exp_map(int'(a), q1, t1, ovf1)));
    check("d1_valid", 32'(bus1.valid), 32'(q1.size() > 0));
    check("d1_ovf", 32'(bus1.overflow), 32'(ovf1));
  endtask

  task automatic idle(input logic [3:0] a);
    step('0, 1'b0, a, 1'b0, 1'b0);
  endtask

  // Reset pulse confined to the low clock phase, with outputs checked while it is held.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_d0_out", 32'(bus0.parallel_out), 32'h0);
    check("rst_d0_valid", 32'(bus0.valid), 32'h0);
    check("rst_d1_ovf", 32'(bus1.overflow), 32'h0);
    #1 reset = 1'b0;
    q0.delete(); q1.delete(); t0.delete(); t1.delete();
    ovf0 = 1'b0; ovf1 = 1'b0; tb_ts = '0;
  endtask

  logic [7:0] lo1, hi1, lo2, hi2;
  logic [7:0] exp_heads [4] = '{8'hB0, 8'hC0, 8'hD0, 8'h00};

  initial begin
    bus0.frame_data = '0; bus0.frame_valid = 1'b0; bus0.address = '0;
    bus0.pop = 1'b0; bus0.clear_ovf = 1'b0;
    ovf0 = 1'b0; ovf1 = 1'b0; tb_ts = '0;
    @(negedge clock);
    @(negedge clock);
    check("reset_out", 32'(bus0.parallel_out), 32'h0);
    check("reset_valid", 32'(bus0.valid), 32'h0);
    check("reset_ovf", 32'(bus0.overflow), 32'h0);
    reset = 1'b0;

    idle(4'd15);
    check("empty_status", 32'(bus0.parallel_out), 32'h20);
    check("empty_valid", 32'(bus0.valid), 32'h0);

    step(mk(8'h01), 1'b1, 4'd0, 1'b0, 1'b0);
    check("first_b0", 32'(bus0.parallel_out), 32'h01);
    idle(4'd11);
    check("first_b11", 32'(bus0.parallel_out), 32'h0C);
    idle(4'd15);
    check("one_status", 32'(bus0.parallel_out), 32'h01);
    check("one_valid", 32'(bus0.valid), 32'h1);
    step('0, 1'b0, 4'd0, 1'b1, 1'b0);

    for (int k = 0; k < 5; k++)
      step(mk(8'hA0 + 8'(k*16)), 1'b1, 4'd15, 1'b0, 1'b0);
    check("full_ovf_status0", 32'(bus0.parallel_out), 32'hC4);
    check("full_ovf_status1", 32'(bus1.parallel_out), 32'hC4);
    idle(4'd0);
    check("drop_new_head", 32'(bus0.parallel_out), 32'hA0);
    check("drop_old_head", 32'(bus1.parallel_out), 32'hB0);
    for (int k = 0; k < 4; k++) begin
      step('0, 1'b0, 4'd0, 1'b1, 1'b0);
      check("pop_order", 32'(bus0.parallel_out), 32'(exp_heads[k]));
    end
    idle(4'd15);
    check("drained_ovf_status", 32'(bus0.parallel_out), 32'hA0);
    step('0, 1'b0, 4'd15, 1'b0, 1'b1);
    check("cleared_status", 32'(bus0.parallel_out), 32'h20);

    for (int k = 0; k < 4; k++)
      step(mk(8'h60 + 8'(k*16)), 1'b1, 4'd0, 1'b0, 1'b0);
    step(mk(8'h50), 1'b1, 4'd15, 1'b1, 1'b0);
    check("full_wr_pop_status", 32'(bus0.parallel_out), 32'h44);
    check("full_wr_pop_ovf", 32'(bus0.overflow), 32'h0);
    idle(4'd0);
    check("full_wr_pop_head", 32'(bus0.parallel_out), 32'h70);
    repeat (3) step('0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("new_frame_last", 32'(bus0.parallel_out), 32'h50);
    repeat (2) step('0, 1'b0, 4'd15, 1'b1, 1'b0);

    for (int n = 0; n < 800; n++) begin
      step({$urandom, $urandom, $urandom},
           ($urandom_range(0, 9) < 4),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 19) == 0));
      if (n % 200 == 199) begin
        pulse_reset();
        idle(4'd15);
        check("midstream_reset_status", 32'(bus0.parallel_out), 32'h20);
      end
    end

`ifdef SNAPSHOT_TIMESTAMP_EN
    pulse_reset();
    while (tb_ts != 16'hFFF8) idle(4'd15);
    step(mk(8'h01), 1'b1, 4'd12, 1'b0, 1'b0);
    check("ts_capture_lo", 32'(bus0.parallel_out), 32'hF8);
    repeat (9) idle(4'd15);
    step(mk(8'h02), 1'b1, 4'd15, 1'b0, 1'b0);
    idle(4'd12); lo1 = bus0.parallel_out;
    idle(4'd13); hi1 = bus0.parallel_out;
    step('0, 1'b0, 4'd12, 1'b1, 1'b0); lo2 = bus0.parallel_out;
    idle(4'd13); hi2 = bus0.parallel_out;
    check("ts_delta", 32'(16'({hi2, lo2} - {hi1, lo1})), 32'd10);
    check("ts_wrapped", 32'({hi2, lo2}), 32'h0002);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
